// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: control-transfer encodings and BTB payload.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_COND = 2'b00,
    BP_JUMP = 2'b01,
    BP_CALL = 2'b10,
    BP_RET  = 2'b11
  } bp_type_e;

  // Width-independent part of a BTB entry; valid, tag and ctr are sized by the instance.
  typedef struct packed {
    bp_type_e    btype;
    logic [31:0] target;
  } btb_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack, updated non-speculatively at EX resolution.
module bp_ras
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] data_i,
  output logic [31:0] top_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ptr_q is the next free slot; a full push overwrites the oldest entry.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && cnt_q != '0) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= data_i;
  end

  assign top_o   = mem_q[ptr_q - PTR_W'(1)];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters; optional return-address stack under BP_RAS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_type,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] recover_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || CTR_W < 1 ||
      RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 ||
      IDX_W + TAG_W + 2 > 32) begin : g_param_err
    $error("branch_predictor: illegal parameter combination");
  end

  logic             valid_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  btb_entry_t       ent_q   [ENTRIES];
  logic [31:0]      br_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, up_wr;
  logic [CTR_W-1:0] ctr_d;
  logic [31:0]      ret_target;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_wr  = upd_valid && (up_hit || upd_taken);

`ifdef BP_RAS_EN
  logic [31:0] ras_top;
  logic        ras_empty;

  bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (upd_valid && upd_type == BP_CALL),
    .pop_i   (upd_valid && upd_type == BP_RET),
    .data_i  (pc_plus4(upd_pc)),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );

  assign ret_target = ras_empty ? ent_q[lk_idx].target : ras_top;
`else
  assign ret_target = ent_q[lk_idx].target;
`endif

  // IF lookup: sees only committed state, so same-cycle updates are not bypassed.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4(if_pc);
    if (lk_hit) begin
      case (ent_q[lk_idx].btype)
        BP_COND: begin
          if (ctr_q[lk_idx][CTR_W-1]) begin
            pred_taken  = 1'b1;
            pred_target = ent_q[lk_idx].target;
          end
        end
        BP_RET: begin
          pred_taken  = 1'b1;
          pred_target = ret_target;
        end
        default: begin
          pred_taken  = 1'b1;
          pred_target = ent_q[lk_idx].target;
        end
      endcase
    end
  end

  assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && upd_target != upd_pred_target));
  assign recover_pc = upd_taken ? upd_target : pc_plus4(upd_pc);

  // Saturating counter step on a hit; fresh allocations start weakly taken.
  always_comb begin
    ctr_d = ctr_q[up_idx];
    if (!up_hit) begin
      ctr_d = CTR_INIT;
    end else if (upd_taken) begin
      if (ctr_q[up_idx] != CTR_MAX) ctr_d = ctr_q[up_idx] + CTR_W'(1);
    end else begin
      if (ctr_q[up_idx] != '0) ctr_d = ctr_q[up_idx] - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (up_wr) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= ctr_d;
      end
      if (upd_valid && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Tag and payload need no reset: they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (up_wr) begin
      tag_q[up_idx]       <= up_tag;
      ent_q[up_idx].btype <= bp_type_e'(upd_type);
      if (upd_taken) ent_q[up_idx].target <= upd_target;
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
